agc_gain_apply: RTL and testbench

//  Downstream stage of agc: takes the 32-bit gain word agc produces and applies
//  it to the 16-bit I/Q sample stream. Output feeds the rx controlled buffer.

---
 rtl/agc_pkg.sv | 40 ++++
 rtl/agc_gain_apply_if.sv | 14 +
 rtl/agc_scale_sat.sv | 55 +++++
 rtl/agc_gain_apply.sv | 89 ++++++++
 tb/tb_agc_gain_apply.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/agc_pkg.sv
// Shared widths, types and the gain-slew helper for the agc gain-apply path.
package agc_pkg;

    localparam int GAIN_W   = 32;
    localparam int SAMPLE_W = 16;
    localparam int FRAC_W   = 16;
    localparam int PROD_W   = SAMPLE_W + GAIN_W + 1;
    localparam int CNT_W    = 16;
    localparam int PIPE_LAT = 3;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic [GAIN_W-1:0]          gain_t;
    typedef logic signed [PROD_W-1:0]   prod_t;

    localparam gain_t GAIN_UNITY = 32'h0001_0000;

    typedef struct packed {
        logic    valid;
        logic    last;
        sample_t i;
        sample_t q;
        gain_t   gain;
    } stage1_t;

    // Move applied gain toward target by at most step; 33-bit signed diff cannot wrap.
    function automatic gain_t slew_gain(gain_t target, gain_t applied, gain_t step);
        logic signed [GAIN_W:0] diff;
        logic signed [GAIN_W:0] step_s;
        diff   = $signed({1'b0, target}) - $signed({1'b0, applied});
        step_s = $signed({1'b0, step});
        if (diff > step_s) begin
            return applied + step;
        end else if (diff < -step_s) begin
            return applied - step;
        end else begin
            return target;
        end
    endfunction

endpackage

// File: rtl/agc_gain_apply_if.sv
// Valid/ready sample stream carrying one I/Q pair and a frame marker per beat.
interface agc_gain_apply_if;
    import agc_pkg::*;

    logic    valid;
    logic    ready;
    sample_t sample_i;
    sample_t sample_q;
    logic    last;

    modport master (output valid, output sample_i, output sample_q, output last, input ready);
    modport slave  (input valid, input sample_i, input sample_q, input last, output ready);

endinterface

// File: rtl/agc_scale_sat.sv
// One channel of the scaler: registered multiply, then round-half-up and clamp to 16 bits.
module agc_scale_sat
    import agc_pkg::*;
(
    input  logic    clk,
    input  logic    arst,
    input  logic    en,
    input  sample_t sample,
    input  gain_t   gain,
    output sample_t result,
    output logic    clip
);

    localparam prod_t HALF    = prod_t'(2 ** (FRAC_W - 1));
    localparam prod_t SAT_MAX = prod_t'(2 ** (SAMPLE_W - 1) - 1);
    localparam prod_t SAT_MIN = prod_t'(-(2 ** (SAMPLE_W - 1)));

    prod_t   sample_ext;
    prod_t   gain_ext;
    prod_t   prod_d;
    prod_t   prod_q;
    prod_t   rounded;
    sample_t result_d;
    logic    clip_d;

    assign sample_ext = {{(PROD_W - SAMPLE_W){sample[SAMPLE_W-1]}}, sample};
    assign gain_ext   = {{(PROD_W - GAIN_W){1'b0}}, gain};
    assign prod_d     = sample_ext * gain_ext;

    always_comb begin
        rounded  = (prod_q + HALF) >>> FRAC_W;
        result_d = rounded[SAMPLE_W-1:0];
        clip_d   = 1'b0;
        if (rounded > SAT_MAX) begin
            result_d = {1'b0, {(SAMPLE_W - 1){1'b1}}};
            clip_d   = 1'b1;
        end else if (rounded < SAT_MIN) begin
            result_d = {1'b1, {(SAMPLE_W - 1){1'b0}}};
            clip_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            prod_q <= '0;
            result <= '0;
            clip   <= 1'b0;
        end else if (en) begin
            prod_q <= prod_d;
            result <= result_d;
            clip   <= clip_d;
        end
    end

endmodule

// File: rtl/agc_gain_apply.sv
// Applies the slewed agc gain to the I/Q stream through a 3-stage stallable pipeline
// and counts output samples that had to be clipped.
module agc_gain_apply
    import agc_pkg::*;
#(
    parameter gain_t GAIN_RESET = GAIN_UNITY,
    parameter gain_t GAIN_STEP  = 32'h0000_1000
)(
    input  logic             clk,
    input  logic             arst,
    input  gain_t            gain,
    input  logic             sat_clr,
    agc_gain_apply_if.slave  s,
    agc_gain_apply_if.master m,
    output gain_t            gain_applied,
    output logic [CNT_W-1:0] sat_count
);

    stage1_t st1;
    logic    en;
    logic    accept;
    logic    xfer;
    logic    valid2;
    logic    last2;
    logic    clip_i;
    logic    clip_q;

    // Whole pipe moves together whenever the output slot is free or being drained.
    assign en      = ~m.valid | m.ready;
    assign s.ready = en;
    assign accept  = s.valid & en;
    assign xfer    = m.valid & m.ready;

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            st1          <= '0;
            valid2       <= 1'b0;
            last2        <= 1'b0;
            m.valid      <= 1'b0;
            m.last       <= 1'b0;
            gain_applied <= GAIN_RESET;
        end else if (en) begin
            st1.valid <= s.valid;
            st1.last  <= s.last;
            st1.i     <= s.sample_i;
            st1.q     <= s.sample_q;
            st1.gain  <= gain_applied;
            valid2    <= st1.valid;
            last2     <= st1.last;
            m.valid   <= valid2;
            m.last    <= last2;
            if (accept) begin
                gain_applied <= slew_gain(gain, gain_applied, GAIN_STEP);
            end
        end
    end

    agc_scale_sat u_scale_i (
        .clk    (clk),
        .arst   (arst),
        .en     (en),
        .sample (st1.i),
        .gain   (st1.gain),
        .result (m.sample_i),
        .clip   (clip_i)
    );

    agc_scale_sat u_scale_q (
        .clk    (clk),
        .arst   (arst),
        .en     (en),
        .sample (st1.q),
        .gain   (st1.gain),
        .result (m.sample_q),
        .clip   (clip_q)
    );

    // Clear beats a concurrent increment; a beat clipped on both channels counts once.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            sat_count <= '0;
        end else if (sat_clr) begin
            sat_count <= '0;
        end else if (xfer && (clip_i || clip_q) && (sat_count != '1)) begin
            sat_count <= sat_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_agc_gain_apply.sv
// Scoreboard bench for agc_gain_apply: directed scenarios plus a randomised stream
// checked against an arithmetic reference model.
module tb_agc_gain_apply;
    import agc_pkg::*;

    localparam longint UNITY = 64'h10000;
    localparam longint STEP  = 64'h1000;

    typedef struct {
        longint i;
        longint q;
        logic   last;
        logic   clip;
    } exp_t;

    logic        clk = 1'b0;
    logic        arst;
    gain_t       gain;
    logic        sat_clr;
    gain_t       gain_applied;
    logic [15:0] sat_count;

    agc_gain_apply_if s_bus ();
    agc_gain_apply_if m_bus ();

    agc_gain_apply dut (
        .clk          (clk),
        .arst         (arst),
        .gain         (gain),
        .sat_clr      (sat_clr),
        .s            (s_bus),
        .m            (m_bus),
        .gain_applied (gain_applied),
        .sat_count    (sat_count)
    );

    always #5 clk = ~clk;

    int      vectors     = 0;
    int      miscompares = 0;
    exp_t    exp_q[$];
    exp_t    mon_e;
    longint  model_gain;
    longint  model_cnt;
    longint  rand_tgt;
    logic    prev_stall = 1'b0;
    sample_t prev_i;
    sample_t prev_q;
    logic    prev_last;
    sample_t rnd_i;
    sample_t rnd_q;

    task automatic checkOutput(input string name, input logic signed [63:0] actual,
                               input logic signed [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, required %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic longint floorDiv(longint num, longint den);
        longint qt;
        qt = num / den;
        if ((num % den != 0) && (num < 0)) qt = qt - 1;
        return qt;
    endfunction

    function automatic longint clampSample(longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Reference: exact product, round half toward +inf, clamp.
    function automatic exp_t modelSample(longint i, longint q, logic last, longint g);
        exp_t   e;
        longint ri;
        longint rq;
        ri     = floorDiv(i * g + 32768, 65536);
        rq     = floorDiv(q * g + 32768, 65536);
        e.i    = clampSample(ri);
        e.q    = clampSample(rq);
        e.last = last;
        e.clip = (ri != e.i) || (rq != e.q);
        return e;
    endfunction

    task automatic applyStimulus(input logic valid, input int i, input int q, input logic last,
                                 input logic mready, input longint tgt, input logic clr);
        longint diff;
        @(negedge clk);
        s_bus.valid    = valid;
        s_bus.sample_i = sample_t'(i);
        s_bus.sample_q = sample_t'(q);
        s_bus.last     = last;
        m_bus.ready    = mready;
        gain           = gain_t'(tgt);
        sat_clr        = clr;
        #1;
        if (arst) begin
            checkOutput("gain_applied", gain_applied, model_gain);
            if (valid && s_bus.ready) begin
                exp_q.push_back(modelSample(i, q, last, model_gain));
                diff = tgt - model_gain;
                if (diff > STEP) model_gain = model_gain + STEP;
                else if (diff < -STEP) model_gain = model_gain - STEP;
                else model_gain = tgt;
            end
        end
    endtask

    // Single sample into an empty pipe; expects it at the output exactly 3 cycles later.
    task automatic sendOne(input int i, input int q, input logic last, input longint tgt,
                           input logic clr_at_out, input longint exp_i, input longint exp_qv);
        int lat;
        lat = 0;
        repeat (4) applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, tgt, 1'b0);
        applyStimulus(1'b1, i, q, last, 1'b1, tgt, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, tgt, clr_at_out && (k == 3));
            #2;
            if (m_bus.valid) begin
                lat = k;
                break;
            end
        end
        checkOutput("latency", lat, 3);
        if (lat != 0) begin
            checkOutput("direct_i", m_bus.sample_i, exp_i);
            checkOutput("direct_q", m_bus.sample_q, exp_qv);
        end
    endtask

    // Monitor: pops the scoreboard on each output transfer and tracks the clip counter.
    always @(negedge clk) begin
        #2;
        if (!arst) begin
            prev_stall = 1'b0;
        end else begin
            checkOutput("sat_count", sat_count, model_cnt);
            if (prev_stall) begin
                checkOutput("hold_valid", m_bus.valid, 1);
                checkOutput("hold_i", m_bus.sample_i, prev_i);
                checkOutput("hold_q", m_bus.sample_q, prev_q);
                checkOutput("hold_last", m_bus.last, prev_last);
            end
            if (m_bus.valid && m_bus.ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_output: got I=%0d Q=%0d, required no output",
                             m_bus.sample_i, m_bus.sample_q);
                    mon_e.clip = 1'b0;
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("out_i", m_bus.sample_i, mon_e.i);
                    checkOutput("out_q", m_bus.sample_q, mon_e.q);
                    checkOutput("out_last", m_bus.last, mon_e.last);
                end
                if (!sat_clr && mon_e.clip && model_cnt < 65535) model_cnt = model_cnt + 1;
            end
            if (sat_clr) model_cnt = 0;
            prev_stall = m_bus.valid && !m_bus.ready;
            prev_i     = m_bus.sample_i;
            prev_q     = m_bus.sample_q;
            prev_last  = m_bus.last;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        arst           = 1'b0;
        s_bus.valid    = 1'b0;
        s_bus.sample_i = '0;
        s_bus.sample_q = '0;
        s_bus.last     = 1'b0;
        m_bus.ready    = 1'b1;
        gain           = gain_t'(UNITY);
        sat_clr        = 1'b0;
        model_gain     = UNITY;
        model_cnt      = 0;
        mon_e.clip     = 1'b0;

        repeat (3) @(negedge clk);
        #3;
        checkOutput("rst_m_valid", m_bus.valid, 0);
        checkOutput("rst_m_i", m_bus.sample_i, 0);
        checkOutput("rst_sat_count", sat_count, 0);
        checkOutput("rst_gain", gain_applied, UNITY);
        @(negedge clk);
        arst = 1'b1;

        $display("[TB] unity gain");
        sendOne(5000, 3000, 1'b1, UNITY, 1'b0, 5000, 3000);

        $display("[TB] slew toward 0x20000 with bubbles");
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(1'b1, k * 100, -k * 50, 1'b0, 1'b1, 64'h20000, 1'b0);
            applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 64'h20000, 1'b0);
            checkOutput("slew_step", gain_applied, UNITY + k * STEP);
        end
        repeat (3) applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 64'h20000, 1'b0);
        checkOutput("slew_hold", gain_applied, 64'h20000);

        $display("[TB] clear versus concurrent clip");
        sendOne(20000, 0, 1'b0, 64'h20000, 1'b0, 32767, 0);
        sendOne(20000, 0, 1'b0, 64'h20000, 1'b1, 32767, 0);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 64'h20000, 1'b0);
        #2;
        checkOutput("clr_wins", sat_count, 0);

        $display("[TB] saturation at gain 0x80000");
        repeat (115) applyStimulus(1'b1, 0, 0, 1'b0, 1'b1, 64'h80000, 1'b0);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 64'h80000, 1'b1);
        checkOutput("gain_at_8x", gain_applied, 64'h80000);
        sendOne(5000, -7000, 1'b0, 64'h80000, 1'b0, 32767, -32768);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 64'h80000, 1'b0);
        #2;
        checkOutput("sat_once", sat_count, 1);

        $display("[TB] rounding at gain 0x8000");
        repeat (125) applyStimulus(1'b1, 0, 0, 1'b0, 1'b1, 64'h8000, 1'b0);
        checkOutput("gain_at_half", gain_applied, 64'h8000);
        sendOne(3, -3, 1'b0, 64'h8000, 1'b0, 2, -1);
        sendOne(1, -1, 1'b0, 64'h8000, 1'b0, 1, 0);

        $display("[TB] backpressure");
        for (int j = 0; j < 6; j++) begin
            applyStimulus(1'b1, 100 + j, -100 - j, j == 5, 1'b1, UNITY, 1'b0);
        end
        for (int j = 0; j < 5; j++) begin
            applyStimulus(1'b1, 999, 999, 1'b1, 1'b0, UNITY, 1'b0);
            checkOutput("bp_s_ready", s_bus.ready, 0);
        end
        repeat (6) applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, UNITY, 1'b0);

        $display("[TB] randomised stream");
        rand_tgt = UNITY;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 31) == 0) rand_tgt = longint'($urandom_range(0, 32'h60000));
            rnd_i = sample_t'($urandom);
            rnd_q = sample_t'($urandom);
            applyStimulus($urandom_range(0, 3) != 0, int'(rnd_i), int'(rnd_q),
                          1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7, rand_tgt,
                          $urandom_range(0, 49) == 0);
        end
        repeat (8) applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, rand_tgt, 1'b0);
        checkOutput("queue_empty", exp_q.size(), 0);

        $display("[TB] reset with samples in flight");
        for (int j = 0; j < 3; j++) begin
            applyStimulus(1'b1, 700 * j + 1, -300, j == 2, 1'b1, 64'h30000, 1'b0);
        end
        @(negedge clk);
        arst        = 1'b0;
        s_bus.valid = 1'b0;
        exp_q.delete();
        model_gain  = UNITY;
        model_cnt   = 0;
        #3;
        checkOutput("mid_rst_m_valid", m_bus.valid, 0);
        checkOutput("mid_rst_sat_count", sat_count, 0);
        checkOutput("mid_rst_gain", gain_applied, UNITY);
        repeat (2) @(negedge clk);
        arst = 1'b1;
        repeat (5) applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, UNITY, 1'b0);
        sendOne(1234, -4321, 1'b1, UNITY, 1'b0, 1234, -4321);
        repeat (3) applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, UNITY, 1'b0);
        checkOutput("final_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
